// File: rtl/alucodes_r32i_pkg.sv
// Shared RV32I ALU opcode encoding and datapath widths.
// Imported by the decoder and every ALU stage.
package alucodes_r32i_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    // The encoding is {funct7[5], funct3}. CPY carries the LUI immediate through unchanged.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SSL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SSR  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101,
        ALU_CPY  = 4'b1111
    } alucode_e;

endpackage

// File: rtl/alu_r32i_core.sv
// Combinational RV32I ALU datapath: operands and opcode in, next result out.
// The optional next_zero output is present only when ALUR32I_ZERO_FLAG_EN is defined.
module alu_r32i_core
    import alucodes_r32i_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alucode,
    output logic [DATA_W-1:0] next_result
`ifdef ALUR32I_ZERO_FLAG_EN
    ,
    output logic              next_zero
`endif
);

    logic [SHAMT_W-1:0] shamt_s;
    logic               lt_signed_s;
    logic               lt_unsigned_s;

    // Shift amount and comparison flags. B[31:5] plays no part in shifts.
    always_comb begin
        shamt_s       = b[SHAMT_W-1:0];
        lt_signed_s   = ($signed(a) < $signed(b));
        lt_unsigned_s = (a < b);
    end

    // Operation select. Illegal codes produce zero.
    always_comb begin
        next_result = {DATA_W{1'b0}};
        case (alucode_e'(alucode))
            ALU_ADD:  next_result = a + b;
            ALU_SSL:  next_result = a << shamt_s;
            ALU_SLT:  next_result = {{(DATA_W-1){1'b0}}, lt_signed_s};
            ALU_SLTU: next_result = {{(DATA_W-1){1'b0}}, lt_unsigned_s};
            ALU_XOR:  next_result = a ^ b;
            ALU_SSR:  next_result = a >> shamt_s;
            ALU_OR:   next_result = a | b;
            ALU_AND:  next_result = a & b;
            ALU_SUB:  next_result = a - b;
            ALU_SRA:  next_result = $unsigned($signed(a) >>> shamt_s);
            ALU_CPY:  next_result = b;
            default:  next_result = {DATA_W{1'b0}};
        endcase
    end

`ifdef ALUR32I_ZERO_FLAG_EN
    // The zero flag follows the result that is about to be registered.
    always_comb begin
        next_zero = (next_result == {DATA_W{1'b0}});
    end
`endif

endmodule

// File: rtl/alu_r32i.sv
// RV32I integer ALU: combinational core followed by an output register with asynchronous reset.
// Defining ALUR32I_ZERO_FLAG_EN adds a registered zero output.
module alu_r32i
    import alucodes_r32i_pkg::*;
#(
    parameter int dataW = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    input  logic [3:0]       alucode,
    output logic [dataW-1:0] result
`ifdef ALUR32I_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    logic [dataW-1:0] next_result_s;
    logic [dataW-1:0] result_d;
    logic [dataW-1:0] result_q;
`ifdef ALUR32I_ZERO_FLAG_EN
    logic             next_zero_s;
    logic             zero_d;
    logic             zero_q;
`endif

    alu_r32i_core u_core (
        .a           (A),
        .b           (B),
        .alucode     (alucode),
        .next_result (next_result_s)
`ifdef ALUR32I_ZERO_FLAG_EN
        ,
        .next_zero   (next_zero_s)
`endif
    );

    // Next-state values for the output register.
    always_comb begin
        result_d = next_result_s;
`ifdef ALUR32I_ZERO_FLAG_EN
        zero_d   = next_zero_s;
`endif
    end

    // Output register. Reset drops any in-flight operation and forces a zero result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= {dataW{1'b0}};
`ifdef ALUR32I_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            result_q <= result_d;
`ifdef ALUR32I_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign result = result_q;
`ifdef ALUR32I_ZERO_FLAG_EN
    assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_r32i.sv
// Scoreboard testbench for alu_r32i: directed vectors with hand-computed results.
// Zero-flag checks are included when ALUR32I_ZERO_FLAG_EN is defined.
module tb_alu_r32i;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  alucode;
    logic [31:0] result;
`ifdef ALUR32I_ZERO_FLAG_EN
    logic        zero;
`endif

    int total;
    int bad;

    typedef struct {
        logic [31:0] res;
        logic        z;
        string       name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        string       name;
    } vec_t;

    vec_t vecs[$];

    alu_r32i dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .alucode (alucode),
        .result  (result)
`ifdef ALUR32I_ZERO_FLAG_EN
        ,
        .zero    (zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one operation on the falling edge and record what the next rising edge must produce.
    task automatic issue(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp_res, input string name);
        exp_t e;
        @(negedge clock);
        reset   = rst;
        A       = a;
        B       = b;
        alucode = op;
        e.res   = exp_res;
        e.z     = (exp_res == 32'd0);
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic check_now(input logic [31:0] exp_res, input string name);
        total = total + 1;
        if (result !== exp_res) begin
            bad = bad + 1;
            $display("FAIL %s: result got=%08h want=%08h", name, result, exp_res);
        end
`ifdef ALUR32I_ZERO_FLAG_EN
        total = total + 1;
        if (zero !== (exp_res == 32'd0)) begin
            bad = bad + 1;
            $display("FAIL %s_zero: zero got=%0b want=%0b", name, zero, (exp_res == 32'd0));
        end
`endif
    endtask

    // Monitor: after every rising edge, compare the registered outputs with the oldest expectation.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total = total + 1;
            if (result !== e.res) begin
                bad = bad + 1;
                $display("FAIL %s: result got=%08h want=%08h", e.name, result, e.res);
            end
`ifdef ALUR32I_ZERO_FLAG_EN
            total = total + 1;
            if (zero !== e.z) begin
                bad = bad + 1;
                $display("FAIL %s_zero: zero got=%0b want=%0b", e.name, zero, e.z);
            end
`endif
        end
    end

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [31:0] res, input string name);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res; v.name = name;
        return v;
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        A       = 32'd9;
        B       = 32'd4;
        alucode = 4'b0000;

        vecs.push_back(mk(32'd9,        32'd10,       4'b1000, 32'hFFFF_FFFF, "sub_neg"));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'd1,       4'b0000, 32'h8000_0000, "add_wrap_sign"));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd1,       4'b0000, 32'h0000_0000, "add_carry_out"));
        vecs.push_back(mk(32'd9,        32'd4,        4'b0010, 32'd0,         "slt_gt"));
        vecs.push_back(mk(32'd2,        32'd4,        4'b0010, 32'd1,         "slt_lt"));
        vecs.push_back(mk(32'hFFFF_FFFE, 32'd4,       4'b0010, 32'd1,         "slt_neg"));
        vecs.push_back(mk(32'hFFFF_FFFE, 32'd4,       4'b0011, 32'd0,         "sltu_big"));
        vecs.push_back(mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'b0011, 32'd1,       "sltu_lt"));
        vecs.push_back(mk(32'd7,        32'd7,        4'b0010, 32'd0,         "slt_eq"));
        vecs.push_back(mk(32'd7,        32'd7,        4'b0011, 32'd0,         "sltu_eq"));
        vecs.push_back(mk(32'd9,        32'd5,        4'b0111, 32'd1,         "and"));
        vecs.push_back(mk(32'd9,        32'd5,        4'b0110, 32'd13,        "or"));
        vecs.push_back(mk(32'd9,        32'd5,        4'b0100, 32'd12,        "xor"));
        vecs.push_back(mk(32'd9,        32'd3,        4'b1111, 32'd3,         "cpy"));
        vecs.push_back(mk(32'd9,        32'd1,        4'b0001, 32'd18,        "ssl"));
        vecs.push_back(mk(32'd9,        32'd3,        4'b0101, 32'd1,         "ssr"));
        vecs.push_back(mk(32'hFFFF_FFF7, 32'd3,       4'b1101, 32'hFFFF_FFFE, "sra_neg"));
        vecs.push_back(mk(32'hFFFF_FFF7, 32'd3,       4'b0101, 32'h1FFF_FFFE, "ssr_neg"));
        vecs.push_back(mk(32'd9,        32'h23,       4'b0001, 32'd72,        "ssl_hi_bits"));
        vecs.push_back(mk(32'hFFFF_FFF7, 32'h23,      4'b1101, 32'hFFFF_FFFE, "sra_hi_bits"));
        vecs.push_back(mk(32'd9,        32'd0,        4'b0001, 32'd9,         "ssl_by0"));
        vecs.push_back(mk(32'h8000_0000, 32'd0,       4'b1101, 32'h8000_0000, "sra_by0"));
        vecs.push_back(mk(32'd1,        32'd31,       4'b0001, 32'h8000_0000, "ssl_by31"));
        vecs.push_back(mk(32'h8000_0000, 32'd31,      4'b1101, 32'hFFFF_FFFF, "sra_by31"));
        vecs.push_back(mk(32'h8000_0000, 32'd31,      4'b0101, 32'd1,         "ssr_by31"));
        vecs.push_back(mk(32'd9,        32'd4,        4'b1010, 32'd0,         "illegal_1010"));
        vecs.push_back(mk(32'd9,        32'd4,        4'b1001, 32'd0,         "illegal_1001"));
        vecs.push_back(mk(32'd5,        32'd5,        4'b1000, 32'd0,         "sub_eq_zero"));
        vecs.push_back(mk(32'd9,        32'd4,        4'b0000, 32'd13,        "add_9_4"));

        // Reset is asynchronous: the output must already be clear before any clock edge.
        #2;
        check_now(32'd0, "rst_async");

        issue(1'b1, 32'd9, 32'd4, 4'b0000, 32'd0,  "rst_hold");
        issue(1'b0, 32'd9, 32'd4, 4'b0000, 32'd13, "rst_release_add");

        foreach (vecs[i]) begin
            issue(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].name);
        end

        // A reset asserted mid-stream clears the output at once and discards the pending operation.
        issue(1'b0, 32'd1, 32'd2, 4'b0000, 32'd3, "pre_midrst");
        @(posedge clock);
        #3;
        reset   = 1'b1;
        A       = 32'd5;
        B       = 32'd6;
        alucode = 4'b0000;
        #1;
        check_now(32'd0, "midrst_async");
        issue(1'b1, 32'd5, 32'd6, 4'b0000, 32'd0,  "midrst_hold");
        issue(1'b0, 32'd5, 32'd6, 4'b0000, 32'd11, "after_midrst");

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            @(posedge clock);
            #2;
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: pending got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
